// File: rtl/cam_pkg.sv
// Shared types and constants for the DVP camera capture block.
package cam_pkg;
    localparam int PIX_W = 16;

    typedef enum logic [2:0] {
        S_WAIT_CFG = 3'd0,
        S_SYNC     = 3'd1,
        S_VBLANK   = 3'd2,
        S_IDLE     = 3'd3,
        S_LINE     = 3'd4
    } cam_state_t;

    typedef enum logic [1:0] {
        DECIM_1 = 2'd0,
        DECIM_2 = 2'd1,
        DECIM_4 = 2'd2
    } decim_t;

    // Encoding 3 is reserved and behaves like quarter-rate decimation.
    function automatic decim_t decim_norm(input logic [1:0] d);
        decim_t r;
        case (d)
            2'd0:    r = DECIM_1;
            2'd1:    r = DECIM_2;
            default: r = DECIM_4;
        endcase
        return r;
    endfunction
endpackage

// File: rtl/cam_sync_stage.sv
// Registers the raw sensor pins once and derives the vsync rise / href fall
// events from the registered copy and its one-cycle-old value.
module cam_sync_stage (
    input  logic       pclk,
    input  logic       reset,
    input  logic       i_vsync,
    input  logic       i_href,
    input  logic [7:0] i_data,
    output logic       o_vsync,
    output logic       o_href,
    output logic [7:0] o_data,
    output logic       o_vsync_rise,
    output logic       o_href_fall
);
    logic       r_vsync;
    logic       r_vsync_d;
    logic       r_href;
    logic       r_href_d;
    logic [7:0] r_data;

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_vsync   <= 1'b0;
            r_vsync_d <= 1'b0;
            r_href    <= 1'b0;
            r_href_d  <= 1'b0;
            r_data    <= 8'h00;
        end else begin
            r_vsync   <= i_vsync;
            r_vsync_d <= r_vsync;
            r_href    <= i_href;
            r_href_d  <= r_href;
            r_data    <= i_data;
        end
    end

    assign o_vsync      = r_vsync;
    assign o_href       = r_href;
    assign o_data       = r_data;
    assign o_vsync_rise = r_vsync & ~r_vsync_d;
    assign o_href_fall  = ~r_href & r_href_d;
endmodule

// File: rtl/cam_pixel_capture.sv
// DVP capture: frame/line FSM, byte packer, decimation and line/frame checks,
// all running on the sensor pixel clock.
module cam_pixel_capture
    import cam_pkg::*;
#(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int COORD_W         = 10
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic               config_done,
    input  logic               vsync,
    input  logic               href,
    input  logic [7:0]         cam_data,
    input  logic [1:0]         decim,
    output logic               pix_valid,
    output logic [PIX_W-1:0]   pix_data,
    output logic [COORD_W-1:0] x_coord,
    output logic [COORD_W-1:0] y_coord,
    output logic               frame_start,
    output logic               frame_end,
    output logic               line_err,
    output logic               frame_err,
    output logic [7:0]         frame_count,
    output cam_state_t         dbg_state
);
    // One extra bit so over-long lines stay distinguishable from H_ACTIVE.
    localparam int CNT_W = COORD_W + 1;
    localparam logic [CNT_W-1:0] H_CNT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_OVER = CNT_W'(H_ACTIVE + 1);
    localparam logic [CNT_W-1:0] V_CNT  = CNT_W'(V_ACTIVE);

    logic       w_vsync;
    logic       w_href;
    logic [7:0] w_data;
    logic       w_vsync_rise;
    logic       w_href_fall;

    cam_sync_stage u_sync (
        .pclk         (pclk),
        .reset        (reset),
        .i_vsync      (vsync),
        .i_href       (href),
        .i_data       (cam_data),
        .o_vsync      (w_vsync),
        .o_href       (w_href),
        .o_data       (w_data),
        .o_vsync_rise (w_vsync_rise),
        .o_href_fall  (w_href_fall)
    );

    cam_state_t       r_state;
    decim_t           r_decim;
    logic [CNT_W-1:0] r_rx;
    logic [CNT_W-1:0] r_ry;
    logic             r_phase;
    logic [7:0]       r_hi;

    logic [1:0]         w_shamt;
    logic [CNT_W-1:0]   w_mask;
    logic               w_emit;
    logic               w_last_byte;
    logic [CNT_W-1:0]   w_rx_inc;
    logic [CNT_W-1:0]   w_ry_inc;
    logic               w_line_bad;
    logic               w_line_end;
    logic [CNT_W-1:0]   w_frame_lines;
    logic [COORD_W-1:0] w_x;
    logic [COORD_W-1:0] w_y;
    logic [PIX_W-1:0]   w_pix;

    assign w_shamt     = r_decim;
    assign w_mask      = (CNT_W'(1) << w_shamt) - CNT_W'(1);
    assign w_emit      = (r_rx < H_CNT) && (r_ry < V_CNT) &&
                         ((r_rx & w_mask) == '0) && ((r_ry & w_mask) == '0);
    assign w_last_byte = (BYTES_PER_PIXEL == 1) || r_phase;
    assign w_rx_inc    = (r_rx == H_OVER) ? r_rx : r_rx + CNT_W'(1);
    assign w_ry_inc    = (r_ry == V_CNT) ? r_ry : r_ry + CNT_W'(1);
    assign w_line_bad  = r_phase || (r_rx != H_CNT);
    assign w_line_end  = (r_state == S_LINE) && w_href_fall;
    // A line ending in the same cycle as the vsync rise still counts toward the frame.
    assign w_frame_lines = w_line_end ? w_ry_inc : r_ry;
    assign w_x         = COORD_W'(r_rx >> w_shamt);
    assign w_y         = COORD_W'(r_ry >> w_shamt);
    assign w_pix       = (BYTES_PER_PIXEL == 1) ? {8'h00, w_data} : {r_hi, w_data};

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state     <= S_WAIT_CFG;
            r_decim     <= DECIM_1;
            r_rx        <= '0;
            r_ry        <= '0;
            r_phase     <= 1'b0;
            r_hi        <= 8'h00;
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            x_coord     <= '0;
            y_coord     <= '0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= 8'h00;
        end else begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
            if (!config_done) begin
                r_state <= S_WAIT_CFG;
            end else begin
                case (r_state)
                    S_WAIT_CFG: r_state <= S_SYNC;
                    S_SYNC: if (w_vsync_rise) r_state <= S_VBLANK;
                    S_VBLANK: begin
                        if (!w_vsync) begin
                            r_state     <= S_IDLE;
                            r_decim     <= decim_norm(decim);
                            frame_start <= 1'b1;
                            r_rx        <= '0;
                            r_ry        <= '0;
                            r_phase     <= 1'b0;
                        end
                    end
                    S_IDLE, S_LINE: begin
                        if (w_vsync_rise) begin
                            line_err    <= (r_state == S_LINE) && (!w_href_fall || w_line_bad);
                            frame_end   <= 1'b1;
                            frame_count <= frame_count + 8'd1;
                            frame_err   <= (w_frame_lines != V_CNT);
                            r_state     <= S_VBLANK;
                        end else if (w_line_end) begin
                            line_err <= w_line_bad;
                            r_rx     <= '0;
                            r_phase  <= 1'b0;
                            r_ry     <= w_ry_inc;
                            r_state  <= S_IDLE;
                        end else if (w_href) begin
                            r_state <= S_LINE;
                            if (w_last_byte) begin
                                if (w_emit) begin
                                    pix_valid <= 1'b1;
                                    pix_data  <= w_pix;
                                    x_coord   <= w_x;
                                    y_coord   <= w_y;
                                end
                                r_rx <= w_rx_inc;
                            end else begin
                                r_hi <= w_data;
                            end
                            r_phase <= (BYTES_PER_PIXEL == 2) ? ~r_phase : 1'b0;
                        end
                    end
                    default: r_state <= S_WAIT_CFG;
                endcase
            end
        end
    end

    assign dbg_state = r_state;
endmodule

// File: doc/cam_pixel_capture.md
# cam_pixel_capture

Parametrised DVP camera capture for OV7670-class sensors, clocked by the sensor pixel clock. Registers the raw 8-bit bus and assembles 1- or 2-byte pixels (RGB565 by default), producing a valid-qualified pixel stream with frame-relative coordinates. Supports runtime 1/2/4 decimation, rejects partial frames, and flags malformed lines and frames. Sits between the sensor pins and the frame-buffer write port.

## Interface
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- BYTES_PER_PIXEL, 2, 1 (raw/Y8) or 2 (RGB565); other values illegal
- COORD_W, 10, coordinate width; must hold H_ACTIVE-1 and V_ACTIVE-1
- pclk  in  1  sensor pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- config_done  in  1  sensor register init complete (level)
- vsync  in  1  sensor VSYNC, active-high during vertical blank
- href  in  1  sensor HREF, high while line bytes valid
- cam_data  in  8  sensor data bus
- decim  in  2  0 = full, 1 = 1/2, 2 = 1/4 in both axes; 3 treated as 2; sampled only at frame start
- pix_valid  out  1  pix_data, x_coord and y_coord valid this cycle
- pix_data  out  16  pixel; first byte in [15:8], second in [7:0]; 1-byte mode gives {8'h00, byte}
- x_coord  out  COORD_W  decimated column
- y_coord  out  COORD_W  decimated row
- frame_start  out  1  one-cycle pulse, first cycle of a frame's active region
- frame_end  out  1  one-cycle pulse on vsync rise ending an accepted frame
- line_err  out  1  one-cycle pulse for a malformed line
- frame_err  out  1  one-cycle pulse coincident with frame_end when line count ≠ V_ACTIVE
- frame_count  out  8  accepted frames; wraps 255→0

## Operation
- Input stage: vsync, href and cam_data are registered once. The FSM acts only on the registered copies. vsync_rise and href_fall are detected from registered and previous values.
- States:
  - S_WAIT_CFG: waits for config_done=1, then → S_SYNC.
  - S_SYNC: waits for vsync_rise, then → S_VBLANK. This discards any frame already in progress.
  - S_VBLANK: on registered vsync=0 → S_IDLE; latches decim; pulses frame_start; clears x, y and byte phase.
  - S_IDLE: registered href=1 → S_LINE. vsync_rise → S_VBLANK and closes the frame.
  - S_LINE: each byte with href=1 toggles the byte phase. On the last byte of a pixel, raw column rx increments.
    - href_fall → S_IDLE. Checks the line, clears rx and phase, and increments raw row ry. ry saturates at V_ACTIVE.
    - vsync_rise while in S_LINE closes the frame and also flags line_err.
- Frame close: pulses frame_end, increments frame_count, and pulses frame_err if ry ≠ V_ACTIVE. Then → S_VBLANK.
- Pixel emit: a pixel is emitted when rx < H_ACTIVE and ry < V_ACTIVE and the low decim bits of rx and ry are both 0.
  - x_coord = rx >> decim, y_coord = ry >> decim.
  - Pixels past H_ACTIVE, or lines past V_ACTIVE, are dropped silently. No wrap.
- line_err fires when, at href_fall, byte phase ≠ 0 (half pixel) or the pixel count ≠ H_ACTIVE.
- config_done falling in any state → S_WAIT_CFG. No frame_end is pulsed.

## Timing
- Reset: state S_WAIT_CFG. All outputs 0: pix_valid, pix_data, coords, pulses and frame_count.
- Latency: a pixel's last byte on cam_data at edge N is registered at N. pix_valid is high in the cycle after edge N+1, for exactly one cycle per pixel.
- In 2-byte mode, pix_valid is high at most every other cycle.
- frame_start follows the registered vsync fall by one cycle. frame_end follows the registered vsync rise by one cycle.
- Simultaneous href_fall and vsync_rise: line check first, then frame close, in the same cycle. ry counts that line.
- Reset mid-frame: outputs are cleared next edge. The next pix_valid occurs only after config_done, a full vsync rise and a vsync fall.

## Structure
- cam_pkg holds:
  - the state enum: S_WAIT_CFG, S_SYNC, S_VBLANK, S_IDLE, S_LINE;
  - the decim_t enum;
  - the PIX_W=16 constant.
- Sub-module cam_sync_stage: input register plus the vsync_rise and href_fall edge detectors, one instance.
- The top-level holds the FSM, counters, byte packer and checks.

## Test plan
- config_done=1, full 640×480 frame, 2 bytes/pixel, bytes 0xAB,0xCD → 307200 pix_valid; pixel (0,0)=0xABCD; last coords (639,479); frame_end=1, frame_err=0, frame_count=1.
- decim=1, full frame → 76800 pixels, max coords (319,239); decim changed mid-frame has no effect until the next frame_start.
- Line with 1281 bytes, then a line with 600 pixels → line_err pulses twice; the 600-pixel line still emits x 0..599.
- Capture starts with vsync low mid-frame → no pix_valid until a vsync rise and fall; then one clean frame, frame_count=1.
- Only 479 lines before vsync rise → frame_end and frame_err both pulse, same cycle.
- reset asserted at line 100 → all outputs 0 next cycle; capture resumes only on the following full frame; frame_count restarts at 0.
